// File: rtl/mmio_gpio_bridge.sv
// mmio_gpio_bridge: memory-mapped GPIO on the data-memory bus.
// Switch inputs pass through a 2-flop synchroniser and a per-bit debouncer.
// LEDs support direct write plus atomic set/clear. Read data is registered,
// giving the same 1-cycle latency as data RAM, and rd_hit qualifies q.
// Optional build macro GPIO_EDGE_IRQ_EN adds rising-edge capture (EDGE_STAT,
// W1C), EDGE_MASK and a maskable irq. Without it, offsets 4/5 read 0 and irq=0.
//
// Register map (word offset from BASE_ADDR):
//   0 SW_DATA  RO   1 LED_DATA RW   2 LED_SET WO   3 LED_CLR WO
//   4 EDGE_STAT R/W1C   5 EDGE_MASK RW   6,7 reserved
module mmio_gpio_bridge #(
    parameter int unsigned IN_W         = 16,
    parameter int unsigned OUT_W        = 16,
    parameter logic [31:0] BASE_ADDR    = 32'd4096,
    parameter int unsigned DEBOUNCE_MAX = 50000,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      address,
    input  logic             wren,
    input  logic [31:0]      data_in,
    output logic             hit,
    output logic             rd_hit,
    output logic [31:0]      q,
    input  logic [IN_W-1:0]  sw_in,
    output logic [OUT_W-1:0] led,
    output logic             irq
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MAX - 1);

    logic [31:0]      offset;
    logic [2:0]       reg_sel;
    logic             wr_en;
    logic [IN_W-1:0]  sync_p0;
    logic [IN_W-1:0]  sync_p1;
    logic [IN_W-1:0]  stable;
    logic [IN_W-1:0]  stable_next;
    logic [CNT_W-1:0] cnt      [IN_W];
    logic [CNT_W-1:0] cnt_next [IN_W];
    logic [31:0]      rd_data;
    logic             unused_data_bits;

    // Unsigned wrap makes addresses below BASE_ADDR land far outside the window.
    assign offset  = address - BASE_ADDR;
    assign hit     = (offset[31:3] == 29'd0);
    assign reg_sel = offset[2:0];
    assign wr_en   = wren && hit;

    // Not every data_in bit is consumed for narrow widths.
    assign unused_data_bits = ^data_in;

    // Two-flop synchroniser for the asynchronous switch pins.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= sw_in;
            sync_p1 <= sync_p0;
        end
    end

    // Per-bit debounce next state: accept a level after DEBOUNCE_MAX differing cycles.
    always_comb begin
        stable_next = stable;
        for (int i = 0; i < IN_W; i++) begin
            cnt_next[i] = cnt[i];
            if (sync_p1[i] == stable[i]) begin
                cnt_next[i] = '0;
            end else if (cnt[i] == CNT_LAST) begin
                stable_next[i] = sync_p1[i];
                cnt_next[i]    = '0;
            end else begin
                cnt_next[i] = cnt[i] + CNT_W'(1);
            end
        end
    end

    // Debounced level and per-bit stability counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stable <= '0;
            for (int i = 0; i < IN_W; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            stable <= stable_next;
            for (int i = 0; i < IN_W; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    // LED register: direct write, atomic set and atomic clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            led <= '0;
        end else if (wr_en) begin
            case (reg_sel)
                3'd1:    led <= data_in[OUT_W-1:0];
                3'd2:    led <= led | data_in[OUT_W-1:0];
                3'd3:    led <= led & ~data_in[OUT_W-1:0];
                default: led <= led;
            endcase
        end
    end

`ifdef GPIO_EDGE_IRQ_EN
    logic [IN_W-1:0] edge_stat;
    logic [IN_W-1:0] edge_mask;
    logic [IN_W-1:0] rise;
    logic [IN_W-1:0] w1c;

    // A rise is seen on the same edge the debouncer accepts the new level.
    assign rise = stable_next & ~stable;
    assign w1c  = (wr_en && reg_sel == 3'd4) ? data_in[IN_W-1:0] : '0;

    // Edge status (set beats clear), mask register and registered interrupt.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            edge_stat <= '0;
            edge_mask <= '0;
            irq       <= 1'b0;
        end else begin
            edge_stat <= (edge_stat & ~w1c) | rise;
            if (wr_en && reg_sel == 3'd5) begin
                edge_mask <= data_in[IN_W-1:0];
            end
            irq <= |(edge_stat & edge_mask);
        end
    end
`else
    assign irq = 1'b0;
`endif

    // Read mux; write-only and reserved offsets return zero.
    always_comb begin
        rd_data = '0;
        case (reg_sel)
            3'd0:    rd_data[IN_W-1:0]  = stable;
            3'd1:    rd_data[OUT_W-1:0] = led;
`ifdef GPIO_EDGE_IRQ_EN
            3'd4:    rd_data[IN_W-1:0]  = edge_stat;
            3'd5:    rd_data[IN_W-1:0]  = edge_mask;
`endif
            default: rd_data = '0;
        endcase
    end

    // Registered read port: pre-write value, zero when outside the window.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q      <= '0;
            rd_hit <= 1'b0;
        end else begin
            rd_hit <= hit;
            q      <= hit ? rd_data : 32'd0;
        end
    end

endmodule

// File: tb/tb_mmio_gpio_bridge.sv
// Bench for mmio_gpio_bridge with DEBOUNCE_MAX=4. A behavioural model tracks
// the expected register state; the debounce rule is evaluated on the history
// of sampled switch values (a level is accepted once it has been seen,
// two samples late, on DEBOUNCE_MAX consecutive edges).
module tb_mmio_gpio_bridge;

    localparam int IN_W  = 16;
    localparam int OUT_W = 16;
    localparam int D     = 4;
    localparam logic [31:0] BASE = 32'd4096;
`ifdef GPIO_EDGE_IRQ_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [31:0]      address = '0;
    logic             wren = 1'b0;
    logic [31:0]      data_in = '0;
    logic [IN_W-1:0]  sw_in = '0;
    logic             hit;
    logic             rd_hit;
    logic [31:0]      q;
    logic [OUT_W-1:0] led;
    logic             irq;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic [15:0] m_led, m_stable, m_stat, m_mask;
    logic        m_irq, m_rd_hit;
    logic [31:0] m_q;
    logic [15:0] hist [8];

    mmio_gpio_bridge #(
        .IN_W(IN_W), .OUT_W(OUT_W), .BASE_ADDR(BASE),
        .DEBOUNCE_MAX(D), .CNT_W(16)
    ) dut (
        .clock(clock), .reset(reset), .address(address), .wren(wren),
        .data_in(data_in), .hit(hit), .rd_hit(rd_hit), .q(q),
        .sw_in(sw_in), .led(led), .irq(irq)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_led = '0; m_stable = '0; m_stat = '0; m_mask = '0;
        m_irq = 1'b0; m_rd_hit = 1'b0; m_q = '0;
        for (int j = 0; j < 8; j++) hist[j] = '0;
    endtask

    // One bus cycle: drive, check hit, clock, then compare against the model.
    task automatic step(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [15:0] s);
        logic        in_win;
        logic [31:0] off, rd;
        logic [15:0] n_led, n_stable, n_stat, n_mask, rise, clr;
        logic        n_irq, all_diff;
        address = a; wren = w; data_in = d; sw_in = s;
        in_win = (a >= BASE) && (a <= BASE + 32'd7);
        off    = a - BASE;
        #1;
        check("hit", {31'b0, hit}, {31'b0, in_win});
        rd = '0;
        if (in_win) begin
            case (off)
                32'd0: rd = {16'b0, m_stable};
                32'd1: rd = {16'b0, m_led};
                32'd4: rd = EDGE_EN ? {16'b0, m_stat} : 32'd0;
                32'd5: rd = EDGE_EN ? {16'b0, m_mask} : 32'd0;
                default: rd = '0;
            endcase
        end
        for (int j = 7; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = s;
        for (int i = 0; i < 16; i++) begin
            all_diff = 1'b1;
            for (int j = 2; j <= D + 1; j++)
                if (hist[j][i] == m_stable[i]) all_diff = 1'b0;
            n_stable[i] = all_diff ? ~m_stable[i] : m_stable[i];
        end
        rise   = n_stable & ~m_stable;
        n_led  = m_led;
        n_mask = m_mask;
        clr    = '0;
        if (in_win && w) begin
            case (off)
                32'd1: n_led = d[15:0];
                32'd2: n_led = m_led | d[15:0];
                32'd3: n_led = m_led & ~d[15:0];
                32'd4: clr = d[15:0];
                32'd5: n_mask = d[15:0];
                default: ;
            endcase
        end
        n_stat = (m_stat & ~clr) | rise;
        n_irq  = EDGE_EN && ((m_stat & m_mask) != 16'd0);
        if (!EDGE_EN) begin
            n_stat = '0;
            n_mask = '0;
        end
        @(posedge clock);
        #1;
        m_led = n_led; m_stable = n_stable; m_stat = n_stat; m_mask = n_mask;
        m_irq = n_irq; m_q = rd; m_rd_hit = in_win;
        check("led", {16'b0, led}, {16'b0, m_led});
        check("q", q, m_q);
        check("rd_hit", {31'b0, rd_hit}, {31'b0, m_rd_hit});
        check("irq", {31'b0, irq}, {31'b0, m_irq});
    endtask

    initial begin : main
        logic [15:0] cur_sw;
        int          hold;
        logic [31:0] a;

        // reset state
        model_reset();
        repeat (2) @(posedge clock);
        #2;
        check("rst_led", {16'b0, led}, 32'd0);
        check("rst_q", q, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        check("rst_rd_hit", {31'b0, rd_hit}, 32'd0);
        reset = 1'b1;

        // SW_DATA read with inputs low
        step(BASE, 1'b0, 32'd0, 16'h0000);
        check("sw_zero", q, 32'd0);
        check("sw_zero_rdhit", {31'b0, rd_hit}, 32'd1);

        // debounce latency: accepted on 6th edge, visible in q on the 7th read
        for (int k = 1; k <= 7; k++) begin
            step(BASE, 1'b0, 32'd0, 16'h00A5);
            check("deb_lat", q, (k == 7) ? 32'h000000A5 : 32'd0);
        end
        // 2-cycle glitch on bit 0 is filtered
        step(BASE, 1'b0, 32'd0, 16'h00A4);
        step(BASE, 1'b0, 32'd0, 16'h00A4);
        for (int k = 0; k < 8; k++) begin
            step(BASE, 1'b0, 32'd0, 16'h00A5);
            check("glitch", q, 32'h000000A5);
        end

        // LED write / set / clear, each read back one cycle later
        step(BASE + 1, 1'b1, 32'h1234, 16'h00A5);
        check("led_wr", {16'b0, led}, 32'h1234);
        step(BASE + 1, 1'b0, 32'd0, 16'h00A5);
        check("led_rd1", q, 32'h1234);
        step(BASE + 2, 1'b1, 32'h000F, 16'h00A5);
        check("led_set", {16'b0, led}, 32'h123F);
        check("led_set_q", q, 32'd0);
        step(BASE + 1, 1'b0, 32'd0, 16'h00A5);
        check("led_rd2", q, 32'h123F);
        step(BASE + 3, 1'b1, 32'h0204, 16'h00A5);
        check("led_clr", {16'b0, led}, 32'h103B);
        // read and write of LED_DATA in one cycle returns the old value
        step(BASE + 1, 1'b1, 32'h5555, 16'h00A5);
        check("rd_wr_same", q, 32'h103B);
        check("rd_wr_led", {16'b0, led}, 32'h5555);

        // edge capture and interrupt
        step(BASE + 5, 1'b1, 32'h0001, 16'h00A5);
        step(BASE + 4, 1'b1, 32'hFFFF, 16'h00A5);
        for (int k = 0; k < 8; k++) step(BASE, 1'b0, 32'd0, 16'h00A4);
        for (int k = 0; k < 6; k++) step(BASE + 4, 1'b0, 32'd0, 16'h00A5);
        step(BASE + 4, 1'b0, 32'd0, 16'h00A5);
        check("edge_stat", q, EDGE_EN ? 32'h1 : 32'h0);
        check("edge_irq", {31'b0, irq}, EDGE_EN ? 32'h1 : 32'h0);
        step(BASE + 4, 1'b1, 32'h0001, 16'h00A5);
        step(BASE + 4, 1'b0, 32'd0, 16'h00A5);
        check("w1c_stat", q, 32'd0);
        step(BASE + 4, 1'b0, 32'd0, 16'h00A5);
        check("w1c_irq", {31'b0, irq}, 32'd0);
        // W1C coinciding with a new edge: set wins
        for (int k = 0; k < 8; k++) step(BASE, 1'b0, 32'd0, 16'h00A4);
        step(BASE + 4, 1'b1, 32'hFFFF, 16'h00A4);
        for (int k = 0; k < 5; k++) step(BASE, 1'b0, 32'd0, 16'h00A5);
        step(BASE + 4, 1'b1, 32'h0001, 16'h00A5);
        step(BASE + 4, 1'b0, 32'd0, 16'h00A5);
        check("set_wins", q, EDGE_EN ? 32'h1 : 32'h0);

        // out-of-window and reserved accesses
        step(BASE + 8, 1'b1, 32'hFFFF, 16'h00A5);
        check("oow_hi_led", {16'b0, led}, 32'h5555);
        check("oow_hi_q", q, 32'd0);
        step(32'd4095, 1'b1, 32'hFFFF, 16'h00A5);
        check("oow_lo_led", {16'b0, led}, 32'h5555);
        check("oow_lo_rdhit", {31'b0, rd_hit}, 32'd0);
        step(BASE + 6, 1'b1, 32'hFFFF, 16'h00A5);
        step(BASE + 6, 1'b0, 32'd0, 16'h00A5);
        check("resv_q", q, 32'd0);

        // asynchronous reset mid-debounce
        step(BASE + 1, 1'b1, 32'hFFFF, 16'h00A5);
        for (int k = 0; k < 3; k++) step(BASE, 1'b0, 32'd0, 16'h0001);
        #2 reset = 1'b0;
        #1;
        check("arst_led", {16'b0, led}, 32'd0);
        check("arst_q", q, 32'd0);
        check("arst_irq", {31'b0, irq}, 32'd0);
        check("arst_rdhit", {31'b0, rd_hit}, 32'd0);
        model_reset();
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step(BASE, 1'b0, 32'd0, 16'h0001);
            check("rst_redeb", q, (k == 7) ? 32'h1 : 32'd0);
        end

        // randomized traffic against the model
        cur_sw = 16'h0001;
        hold   = 0;
        for (int n = 0; n < 400; n++) begin
            if (hold == 0) begin
                if ($urandom_range(0, 3) == 0) cur_sw = 16'($urandom);
                else cur_sw = cur_sw ^ (16'h1 << $urandom_range(0, 15));
                hold = $urandom_range(1, 8);
            end
            hold--;
            a = BASE - 32'd1 + 32'($urandom_range(0, 9));
            step(a, 1'($urandom_range(0, 1)), $urandom, cur_sw);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
